// File: rtl/mcu_8bit_pkg.sv
// Shared definitions for the 8-bit MCU: fetch state encoding and default widths.
package mcu_8bit_pkg;

   localparam int unsigned DEF_ADDR_WIDTH   = 8;
   localparam int unsigned DEF_INSTR_WIDTH  = 8;
   localparam int unsigned DEF_RESET_VECTOR = 0;

   typedef enum logic {
      s_run  = 1'b0,
      s_halt = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/mcu_8bit_fetch_queue.sv
// Two-entry FIFO of {pc, instr} between the ROM response and the decoder.
module mcu_8bit_fetch_queue
   import mcu_8bit_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   push,
   input  logic [ADDR_WIDTH-1:0]  push_pc,
   input  logic [INSTR_WIDTH-1:0] push_instr,
   input  logic                   pop,
   input  logic                   flush,
   output logic                   head_valid,
   output logic [ADDR_WIDTH-1:0]  head_pc,
   output logic [INSTR_WIDTH-1:0] head_instr,
   output logic [1:0]             occupancy
);

   logic [ADDR_WIDTH-1:0]  pc_reg    [2];
   logic [INSTR_WIDTH-1:0] instr_reg [2];
   logic                   rd_ptr_reg;
   logic                   wr_ptr_reg;
   logic [1:0]             count_reg;
   logic                   push_ok;
   logic                   pop_ok;

   // Flush wins over a same-cycle push so a redirect never lets a stale word in.
   assign push_ok    = push && !flush;
   assign pop_ok     = pop && (count_reg != 2'd0) && !flush;
   assign head_valid = (count_reg != 2'd0);
   assign head_pc    = pc_reg[rd_ptr_reg];
   assign head_instr = instr_reg[rd_ptr_reg];
   assign occupancy  = count_reg;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 2; i++) begin
            pc_reg[i]    <= '0;
            instr_reg[i] <= '0;
         end
         rd_ptr_reg <= 1'b0;
         wr_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else if (flush) begin
         rd_ptr_reg <= 1'b0;
         wr_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push_ok) begin
            pc_reg[wr_ptr_reg]    <= push_pc;
            instr_reg[wr_ptr_reg] <= push_instr;
            wr_ptr_reg            <= ~wr_ptr_reg;
         end
         if (pop_ok)
            rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/mcu_8bit_fetch_unit.sv
// Instruction fetch stage: PC, ROM request issue with credit control, redirect/halt FSM.
module mcu_8bit_fetch_unit
   import mcu_8bit_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int unsigned INSTR_WIDTH  = DEF_INSTR_WIDTH,
   parameter int unsigned RESET_VECTOR = DEF_RESET_VECTOR
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   resetPC,
   input  logic                   i_jump_valid,
   input  logic [ADDR_WIDTH-1:0]  i_jump_addr,
   input  logic                   i_halt,
   output logic                   o_mem_en,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   input  logic [INSTR_WIDTH-1:0] i_mem_data,
   output logic                   o_instr_valid,
   input  logic                   i_instr_ready,
   output logic [INSTR_WIDTH-1:0] o_instr_data,
   output logic [ADDR_WIDTH-1:0]  o_instr_pc,
   output logic [ADDR_WIDTH-1:0]  currentPC
);

   localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_VECTOR);

   fetch_state_t          state_reg;
   logic [ADDR_WIDTH-1:0] pc_reg;
   logic [ADDR_WIDTH-1:0] req_pc_reg;
   logic                  inflight_reg;

   logic       pop;
   logic       redirect;
   logic       issue;
   logic       discard;
   logic       push;
   logic [1:0] occupancy;
   logic [2:0] credits_used;

   assign pop      = o_instr_valid & i_instr_ready;
   assign redirect = resetPC | i_jump_valid;

   // Occupancy plus the outstanding request never exceeds two, so the queue cannot overflow.
   assign credits_used = {1'b0, occupancy} + {2'b0, inflight_reg} - {2'b0, pop};
   assign issue        = !Reset && (state_reg == s_run) && !redirect && (credits_used < 3'd2);

   // With one-cycle ROM latency the only pending response is the one on the bus now.
   assign discard = inflight_reg & redirect;
   assign push    = inflight_reg & ~discard;

   assign o_mem_en   = issue;
   assign o_mem_addr = pc_reg;
   assign currentPC  = pc_reg;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg    <= s_run;
         pc_reg       <= RESET_PC;
         req_pc_reg   <= '0;
         inflight_reg <= 1'b0;
      end else begin
         inflight_reg <= issue;
         if (issue)
            req_pc_reg <= pc_reg;
         if (resetPC) begin
            state_reg <= s_run;
            pc_reg    <= RESET_PC;
         end else if (i_jump_valid) begin
            state_reg <= s_run;
            pc_reg    <= i_jump_addr;
         end else begin
            if (i_halt && state_reg == s_run)
               state_reg <= s_halt;
            if (issue)
               pc_reg <= pc_reg + ADDR_WIDTH'(1);
         end
      end
   end

   mcu_8bit_fetch_queue #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_queue (
      .Clk        (Clk),
      .Reset      (Reset),
      .push       (push),
      .push_pc    (req_pc_reg),
      .push_instr (i_mem_data),
      .pop        (pop),
      .flush      (redirect),
      .head_valid (o_instr_valid),
      .head_pc    (o_instr_pc),
      .head_instr (o_instr_data),
      .occupancy  (occupancy)
   );

endmodule

// File: doc/mcu_8bit_fetch_unit.md
# mcu_8bit_fetch_unit

Instruction fetch stage for the 8-bit MCU, directly upstream of the decode/execute core. Owns the program counter and issues addresses to the synchronous program ROM (1-cycle read latency). Buffers returned instructions in a 2-entry queue and presents them, tagged with their PC, to the decoder over a valid/ready handshake. Handles jump redirects with flush, halt, and PC restart.

## Interface
- ADDR_WIDTH, 8, program address / PC width
- INSTR_WIDTH, 8, instruction word width
- RESET_VECTOR, 0, PC value after Reset or resetPC
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- resetPC  in  1  synchronous restart of PC to RESET_VECTOR
- i_jump_valid  in  1  redirect request from execute (single-cycle pulse)
- i_jump_addr  in  ADDR_WIDTH  redirect target
- i_halt  in  1  HLT decoded; stop issuing fetches (pulse)
- o_mem_en  out  1  ROM read enable
- o_mem_addr  out  ADDR_WIDTH  ROM read address
- i_mem_data  in  INSTR_WIDTH  ROM data, valid the cycle after o_mem_en
- o_instr_valid  out  1  instruction available to decoder
- i_instr_ready  in  1  decoder accepts instruction
- o_instr_data  out  INSTR_WIDTH  instruction word
- o_instr_pc  out  ADDR_WIDTH  address of o_instr_data
- currentPC  out  ADDR_WIDTH  address of the next fetch to be issued

## Operation
- State machine: s_run (issue enabled), s_halt (no issue). Reset and resetPC -> s_run. i_halt in s_run -> s_halt. s_halt exits to s_run only on resetPC or i_jump_valid.
- Pop = o_instr_valid & i_instr_ready.
- Issue when state is s_run, no redirect this cycle, and (occupancy + inflight - pop) < 2. On issue: o_mem_en=1, o_mem_addr=currentPC, currentPC+1 modulo 2^ADDR_WIDTH (2^ADDR_WIDTH-1 wraps to 0), inflight bit set, PC of the request captured.
- Response cycle: i_mem_data plus captured PC written into queue unless discarded; inflight clears unless a new issue occurs in that cycle.
- Redirect (i_jump_valid): currentPC <= i_jump_addr, queue emptied, pending in-flight response marked discard, no issue that cycle. First fetch of target is issued next cycle.
- Priority: Reset > resetPC > i_jump_valid > i_halt > normal. resetPC behaves like a redirect to RESET_VECTOR and also forces s_run.
- Halt: fetches already in flight complete and enter the queue. The queue continues to drain to the decoder.
- Queue never overflows by construction. Pop and push in the same cycle are allowed at any occupancy.

## Timing
- Reset values: o_mem_en=0, o_mem_addr=RESET_VECTOR, currentPC=RESET_VECTOR, o_instr_valid=0, o_instr_data=0, o_instr_pc=0, queue empty, inflight=0, state s_run.
- First o_mem_en in the first rising edge after Reset deasserts. o_mem_en is combinational from state, credits, and redirect inputs.
- Issue at cycle N -> o_instr_valid at N+2 (registered queue, no bypass).
- Sustained throughput is 1 instruction/cycle with i_instr_ready held high.
- After redirect at cycle N: issue of target at N+1, target valid at N+3. o_instr_valid is 0 during N+1..N+2.
- o_instr_data/o_instr_pc are stable while o_instr_valid=1 and i_instr_ready=0.
- Reset mid-operation clears everything immediately (asynchronous). Any ROM response arriving afterwards is ignored because inflight=0.

## Structure
- Shared package mcu_8bit_pkg holds: fetch state encoding (s_run, s_halt), default ADDR_WIDTH/INSTR_WIDTH, RESET_VECTOR.
- One sub-module: mcu_8bit_fetch_queue. This is a 2-entry FIFO of {pc, instr} with push, pop, flush, and occupancy output, plus the same Clk/Reset.
- PC register, credit logic, inflight/discard tracking, and the state machine live in the top.

## Test plan
- Reset held 100 ns, then released with ROM[k]=k+0x10 and ready=1 -> addresses 0,1,2… issued one per cycle. First o_instr_valid 2 cycles after the first o_mem_en with data 0x10, pc 0, followed by a gap-free stream.
- Backpressure: ready=0 for 5 cycles mid-stream -> at most 2 queued plus no further issue. Held outputs stay stable, and no instruction is lost or duplicated on resume.
- Jump to 0x40 while queue is full and a fetch is in flight -> queue flushed and stale response dropped. Next accepted instruction has pc 0x40, valid 3 cycles after the jump pulse.
- i_halt at PC 0x05 -> issuing stops and in-flight/queued instructions drain. o_mem_en stays 0 until i_jump_valid to 0x00, after which fetching resumes at 0x00.
- Wrap: jump to 0xFE, ready=1 -> pcs 0xFE, 0xFF, 0x00, 0x01 delivered in order.
- resetPC pulse in s_halt and mid-stream, plus async Reset asserted between edges -> currentPC=RESET_VECTOR, o_instr_valid=0 immediately on Reset. Subsequent stream restarts from RESET_VECTOR.
